// File: rtl/adc_pkg.sv
// Shared types and defaults for the delta-sigma conversion path.
// The default constants are also consumed by the decimation filter.
package adc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StInteg
    } adc_state_e;

    localparam int unsigned DefaultOsrLog2 = 8;
    localparam int unsigned DefaultSettle  = 16;

    // Result must hold 0..2^osrLog2 inclusive.
    function automatic int unsigned resWidth(input int unsigned osrLog2);
        return osrLog2 + 1;
    endfunction

endpackage

// File: rtl/adc_conv_ctrl_if.sv
// Control/result bundle between the sampling flop, the sequencer and the downstream filter.
// The sequencer takes the slave view; whoever drives requests takes the master view.
interface adc_conv_ctrl_if
    import adc_pkg::*;
#(
    parameter int unsigned OSR_LOG2 = DefaultOsrLog2
) ();

    localparam int unsigned ResW = resWidth(OSR_LOG2);

    logic            adcSample;
    logic            start;
    logic            continuous;
    logic            abort;
    logic            resultReady;
    logic            busy;
    logic            fbDac;
    logic [ResW-1:0] result;
    logic            resultValid;
    logic            overrun;

    modport master (
        output adcSample,
        output start,
        output continuous,
        output abort,
        output resultReady,
        input  busy,
        input  fbDac,
        input  result,
        input  resultValid,
        input  overrun
    );

    modport slave (
        input  adcSample,
        input  start,
        input  continuous,
        input  abort,
        input  resultReady,
        output busy,
        output fbDac,
        output result,
        output resultValid,
        output overrun
    );

endinterface

// File: rtl/adc_window_counter.sv
// Ones accumulator and sample counter for one oversampling window.
// sum includes the current bit so the window total is available on the last cycle.
module adc_window_counter
    import adc_pkg::*;
#(
    parameter int unsigned OSR_LOG2 = DefaultOsrLog2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            enable,
    input  logic                            sample_bit,
    output logic [resWidth(OSR_LOG2)-1:0]   sum,
    output logic                            last
);

    localparam int unsigned ResW = resWidth(OSR_LOG2);

    logic [ResW-1:0]     acc_q, acc_d;
    logic [OSR_LOG2-1:0] cnt_q, cnt_d;

    assign last = &cnt_q;
    assign sum  = acc_q + ResW'(sample_bit);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (enable) begin
            // Window end restarts the accumulator; the counter wraps on its own.
            acc_d = last ? '0 : sum;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_conv_ctrl.sv
// Delta-sigma conversion sequencer: settle, integrate over 2^OSR_LOG2 samples,
// drive the 1-bit feedback DAC and hand results downstream over valid/ready.
module adc_conv_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned OSR_LOG2 = DefaultOsrLog2,
    parameter int unsigned SETTLE   = DefaultSettle
) (
    input logic            clk,
    input logic            rst,
    adc_conv_ctrl_if.slave bus
);

    localparam int unsigned ResW    = resWidth(OSR_LOG2);
    localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SettleW-1:0] SettleLoad =
        (SETTLE == 0) ? '0 : SettleW'(SETTLE - 1);

    adc_state_e       state_q, state_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic             fb_q, fb_d;
    logic [ResW-1:0]  result_q, result_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             win_clear;
    logic             win_enable;
    logic [ResW-1:0]  win_sum;
    logic             win_last;
    logic             load;

    assign win_clear = (state_q != StInteg) || bus.abort;

    adc_window_counter #(
        .OSR_LOG2 (OSR_LOG2)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .clear      (win_clear),
        .enable     (win_enable),
        .sample_bit (bus.adcSample),
        .sum        (win_sum),
        .last       (win_last)
    );

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        fb_d       = 1'b0;
        result_d   = result_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        win_enable = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    overrun_d = 1'b0;
                    if (SETTLE == 0) begin
                        state_d = StInteg;
                    end else begin
                        state_d  = StSettle;
                        settle_d = SettleLoad;
                    end
                end
            end
            StSettle: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    fb_d = bus.adcSample;
                    if (settle_q == '0) begin
                        state_d = StInteg;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
            end
            StInteg: begin
                // Abort wins over window completion: no result loads.
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    fb_d       = bus.adcSample;
                    win_enable = 1'b1;
                    if (win_last) begin
                        load = 1'b1;
                        if (!bus.continuous) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            result_d = win_sum;
            valid_d  = 1'b1;
            if (valid_q && !bus.resultReady) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.resultReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            settle_q  <= '0;
            fb_q      <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            fb_q      <= fb_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.fbDac       = fb_q;
    assign bus.result      = result_q;
    assign bus.resultValid = valid_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Directed bench for adc_conv_ctrl with OSR_LOG2=4, SETTLE=2.
// Edge 0 is the edge that samples start; results are due after edge 18.
module tb_adc_conv_ctrl;

    localparam int unsigned OsrLog2 = 4;
    localparam int unsigned Settle  = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   mode   = 0;  // 0: samples 0, 1: samples 1, 2: alternate

    adc_conv_ctrl_if #(.OSR_LOG2(OsrLog2)) bus ();

    adc_conv_ctrl #(
        .OSR_LOG2 (OsrLog2),
        .SETTLE   (Settle)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (mode == 2) bus.adcSample = ~bus.adcSample;
        else           bus.adcSample = (mode == 1);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.adcSample = 1'b0; bus.start = 1'b0; bus.continuous = 1'b0;
        bus.abort = 1'b0; bus.resultReady = 1'b0;
        #12;
        checks++;
        if ({bus.busy, bus.resultValid, bus.overrun, bus.fbDac, bus.result} !== 9'b0)
            $display("FAIL reset_outputs: got %b want 0", {bus.busy, bus.resultValid,
                     bus.overrun, bus.fbDac, bus.result});
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        ticks(2);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", bus.busy);
        else passes++;
    endtask

    task automatic test_single_ones();
        mode = 1; bus.adcSample = 1'b1; bus.resultReady = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;  // edge 0
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL t1_busy: got %b want 1", bus.busy);
        else passes++;
        tick();  // edge 1, settling
        checks++;
        if (bus.fbDac !== 1'b1) $display("FAIL t1_fb_settle: got %b want 1", bus.fbDac);
        else passes++;
        ticks(16);  // edge 17
        checks++;
        if (bus.resultValid !== 1'b0) $display("FAIL t1_early: valid got %b want 0", bus.resultValid);
        else passes++;
        tick();  // edge 18
        checks++;
        if ({bus.resultValid, bus.busy, bus.result} !== {1'b1, 1'b0, 5'd16})
            $display("FAIL t1_result: valid/busy/result got %b/%b/%0d want 1/0/16",
                     bus.resultValid, bus.busy, bus.result);
        else passes++;
        tick();  // edge 19
        checks++;
        if ({bus.fbDac, bus.resultValid} !== 2'b01)
            $display("FAIL t1_idle: fb/valid got %b/%b want 0/1", bus.fbDac, bus.resultValid);
        else passes++;
        bus.resultReady = 1'b1; tick(); bus.resultReady = 1'b0;
        checks++;
        if (bus.resultValid !== 1'b0) $display("FAIL t1_drain: valid got %b want 0", bus.resultValid);
        else passes++;
    endtask

    task automatic test_patterns();
        bus.resultReady = 1'b1;
        for (int p = 0; p < 2; p++) begin
            mode = (p == 0) ? 2 : 0;
            bus.adcSample = 1'b0;
            bus.start = 1'b1; tick(); bus.start = 1'b0;
            ticks(17);  // edge 17
            checks++;
            if (bus.resultValid !== 1'b0) $display("FAIL t2_early%0d: valid got %b want 0", p,
                                                   bus.resultValid);
            else passes++;
            tick();  // edge 18
            checks++;
            if ({bus.resultValid, bus.result} !== {1'b1, (p == 0) ? 5'd8 : 5'd0})
                $display("FAIL t2_result%0d: valid/result got %b/%0d want 1/%0d", p,
                         bus.resultValid, bus.result, (p == 0) ? 8 : 0);
            else passes++;
            tick();  // edge 19
            checks++;
            if (bus.resultValid !== 1'b0) $display("FAIL t2_pulse%0d: valid got %b want 0", p,
                                                   bus.resultValid);
            else passes++;
        end
        bus.resultReady = 1'b0;
    endtask

    task automatic test_continuous_overrun();
        mode = 1; bus.adcSample = 1'b1; bus.resultReady = 1'b0; bus.continuous = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        ticks(18);  // edge 18
        checks++;
        if ({bus.resultValid, bus.overrun, bus.busy, bus.result} !== {3'b101, 5'd16})
            $display("FAIL t3_first: valid/ovr/busy/result got %b/%b/%b/%0d want 1/0/1/16",
                     bus.resultValid, bus.overrun, bus.busy, bus.result);
        else passes++;
        ticks(15);  // edge 33
        checks++;
        if (bus.overrun !== 1'b0) $display("FAIL t3_no_ovr_yet: got %b want 0", bus.overrun);
        else passes++;
        tick();  // edge 34
        checks++;
        if ({bus.resultValid, bus.overrun, bus.busy, bus.result} !== {3'b111, 5'd16})
            $display("FAIL t3_second: valid/ovr/busy/result got %b/%b/%b/%0d want 1/1/1/16",
                     bus.resultValid, bus.overrun, bus.busy, bus.result);
        else passes++;
        bus.abort = 1'b1; tick(); bus.abort = 1'b0; bus.continuous = 1'b0;
        checks++;
        if ({bus.busy, bus.overrun} !== 2'b01)
            $display("FAIL t3_abort: busy/ovr got %b/%b want 0/1", bus.busy, bus.overrun);
        else passes++;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.overrun} !== 2'b10)
            $display("FAIL t3_restart: busy/ovr got %b/%b want 1/0", bus.busy, bus.overrun);
        else passes++;
        bus.abort = 1'b1; bus.resultReady = 1'b1; tick();
        bus.abort = 1'b0; bus.resultReady = 1'b0;
        checks++;
        if ({bus.busy, bus.resultValid} !== 2'b00)
            $display("FAIL t3_cleanup: busy/valid got %b/%b want 0/0", bus.busy, bus.resultValid);
        else passes++;
    endtask

    task automatic test_back_to_back();
        mode = 1; bus.adcSample = 1'b1; bus.resultReady = 1'b0; bus.continuous = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        ticks(18);  // edge 18
        mode = 0; bus.adcSample = 1'b0;
        checks++;
        if ({bus.resultValid, bus.result} !== {1'b1, 5'd16})
            $display("FAIL t4_first: valid/result got %b/%0d want 1/16", bus.resultValid, bus.result);
        else passes++;
        ticks(7);  // edge 25
        checks++;
        if ({bus.resultValid, bus.busy, bus.result} !== {2'b11, 5'd16})
            $display("FAIL t4_hold: valid/busy/result got %b/%b/%0d want 1/1/16",
                     bus.resultValid, bus.busy, bus.result);
        else passes++;
        bus.continuous = 1'b0;
        ticks(8);  // edge 33
        bus.resultReady = 1'b1;
        tick();  // edge 34: handshake and new load together
        checks++;
        if ({bus.resultValid, bus.overrun, bus.busy, bus.result} !== {3'b100, 5'd0})
            $display("FAIL t4_second: valid/ovr/busy/result got %b/%b/%b/%0d want 1/0/0/0",
                     bus.resultValid, bus.overrun, bus.busy, bus.result);
        else passes++;
        tick();  // edge 35
        checks++;
        if (bus.resultValid !== 1'b0) $display("FAIL t4_drain: valid got %b want 0", bus.resultValid);
        else passes++;
        bus.resultReady = 1'b0;
    endtask

    task automatic test_abort();
        // Pending result of 0 from an all-zeros window.
        mode = 0; bus.adcSample = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        ticks(18);
        for (int a = 0; a < 2; a++) begin
            mode = 1; bus.adcSample = 1'b1;
            bus.start = 1'b1; tick(); bus.start = 1'b0;  // edge 0
            ticks((a == 0) ? 9 : 17);
            bus.abort = 1'b1; bus.start = 1'b1;
            tick();  // edge 10 or 18
            checks++;
            if ({bus.busy, bus.fbDac, bus.resultValid, bus.overrun, bus.result} !== {4'b0010, 5'd0})
                $display("FAIL t5_abort%0d: busy/fb/valid/ovr/result got %b/%b/%b/%b/%0d want 0/0/1/0/0",
                         a, bus.busy, bus.fbDac, bus.resultValid, bus.overrun, bus.result);
            else passes++;
            tick();  // abort still high in idle blocks start
            checks++;
            if (bus.busy !== 1'b0) $display("FAIL t5_blocked%0d: busy got %b want 0", a, bus.busy);
            else passes++;
            bus.abort = 1'b0; bus.start = 1'b0;
        end
        ticks(16);
        checks++;
        if ({bus.resultValid, bus.busy, bus.result} !== {2'b10, 5'd0})
            $display("FAIL t5_no_result: valid/busy/result got %b/%b/%0d want 1/0/0",
                     bus.resultValid, bus.busy, bus.result);
        else passes++;
    endtask

    task automatic test_async_reset();
        mode = 1; bus.adcSample = 1'b1; bus.resultReady = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        ticks(8);  // edge 8, integrating
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.resultValid, bus.overrun, bus.fbDac, bus.result} !== 9'b0)
            $display("FAIL t6_reset: got %b want 0", {bus.busy, bus.resultValid, bus.overrun,
                     bus.fbDac, bus.result});
        else passes++;
        #2;
        rst = 1'b1;
        mode = 2; bus.adcSample = 1'b1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        ticks(17);  // edge 17
        checks++;
        if (bus.resultValid !== 1'b0) $display("FAIL t6_early: valid got %b want 0", bus.resultValid);
        else passes++;
        tick();  // edge 18
        checks++;
        if ({bus.resultValid, bus.result} !== {1'b1, 5'd8})
            $display("FAIL t6_result: valid/result got %b/%0d want 1/8", bus.resultValid, bus.result);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_ones();
        test_patterns();
        test_continuous_overrun();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
